// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  // Sequencer states: hold everything in reset, release channels one by one, idle.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_e;

  // Largest supported channel count and the channel index width it needs.
  localparam int unsigned MAX_CH       = 32'd16;
  localparam int unsigned MAX_CH_IDX_W = $clog2(MAX_CH);

  // Width of the channel index register: clog2(num_ch), at least one bit.
  function automatic int unsigned ch_idx_width(input int unsigned num_ch);
    if (num_ch > 32'd1) begin
      ch_idx_width = $clog2(num_ch);
    end else begin
      ch_idx_width = 32'd1;
    end
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Per-channel clock-enable divider: while run is high, div_cnt counts 0..div
// and the registered clk_en pulses on the wrap. Held idle while run is low.
module clk_en_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             clk_en_q;
  logic             clk_en_d;
  logic             wrap_s;

  // Next divider count and enable pulse; div=0 wraps every cycle (enable stays high).
  always_comb begin
    wrap_s    = (div_cnt_q == div);
    div_cnt_d = '0;
    clk_en_d  = 1'b0;
    if (run) begin
      if (wrap_s) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      clk_en_d = wrap_s;
    end else begin
      div_cnt_d = '0;
      clk_en_d  = 1'b0;
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      div_cnt_q <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_en = clk_en_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds NUM_CH reset domains for HOLD_CYC cycles, then
// releases them in ascending order with per-channel delays, and drives a
// divided clock enable for each released channel.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_reset,
  input  logic [NUM_CH*DLY_W-1:0]   dly_cfg,
  input  logic [NUM_CH*DIV_W-1:0]   div_cfg,
  input  logic                      sw_rst_req,
  output logic [NUM_CH-1:0]         ch_resetn,
  output logic [NUM_CH-1:0]         ch_clk_en,
  output logic                      rst_done,
  output logic                      busy
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYC) + 1;
  localparam int unsigned IDX_W  = ch_idx_width(NUM_CH);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

  seq_state_e                state_q;
  seq_state_e                state_d;
  logic [HOLD_W-1:0]         hold_cnt_q;
  logic [HOLD_W-1:0]         hold_cnt_d;
  logic [IDX_W-1:0]          ch_idx_q;
  logic [IDX_W-1:0]          ch_idx_d;
  logic [DLY_W-1:0]          dly_cnt_q;
  logic [DLY_W-1:0]          dly_cnt_d;
  logic [NUM_CH*DLY_W-1:0]   dly_lat_q;
  logic [NUM_CH*DLY_W-1:0]   dly_lat_d;
  logic [NUM_CH*DIV_W-1:0]   div_lat_q;
  logic [NUM_CH*DIV_W-1:0]   div_lat_d;
  logic [NUM_CH-1:0]         ch_resetn_q;
  logic [NUM_CH-1:0]         ch_resetn_d;
  logic                      rst_done_q;
  logic                      rst_done_d;
  logic                      busy_q;
  logic                      busy_d;
  logic [DLY_W-1:0]          cur_dly_s;
  logic [NUM_CH-1:0]         run_s;

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    ch_idx_d    = ch_idx_q;
    dly_cnt_d   = dly_cnt_q;
    dly_lat_d   = dly_lat_q;
    div_lat_d   = div_lat_q;
    ch_resetn_d = ch_resetn_q;
    rst_done_d  = rst_done_q;
    busy_d      = busy_q;
    cur_dly_s   = dly_lat_q[ch_idx_q*DLY_W +: DLY_W];

    case (state_q)
      ASSERT: begin
        ch_resetn_d = '0;
        rst_done_d  = 1'b0;
        busy_d      = 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          // Hold complete: snapshot the configuration for this whole sequence.
          state_d    = RELEASE;
          hold_cnt_d = '0;
          ch_idx_d   = '0;
          dly_cnt_d  = '0;
          dly_lat_d  = dly_cfg;
          div_lat_d  = div_cfg;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        if (dly_cnt_q == cur_dly_s) begin
          ch_resetn_d = ch_resetn_q | (CH_ONE << ch_idx_q);
          dly_cnt_d   = '0;
          if (ch_idx_q == LAST_CH) begin
            state_d    = DONE;
            rst_done_d = 1'b1;
            busy_d     = 1'b0;
            ch_idx_d   = ch_idx_q;
          end else begin
            ch_idx_d   = ch_idx_q + IDX_W'(1);
          end
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end

      DONE: begin
        if (sw_rst_req) begin
          // Software restart: drop every domain and rerun the hold.
          state_d     = ASSERT;
          hold_cnt_d  = '0;
          ch_idx_d    = '0;
          dly_cnt_d   = '0;
          ch_resetn_d = '0;
          rst_done_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        // Unreachable encoding: recover by restarting the sequence.
        state_d     = ASSERT;
        hold_cnt_d  = '0;
        ch_idx_d    = '0;
        dly_cnt_d   = '0;
        ch_resetn_d = '0;
        rst_done_d  = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  // Sequencer registers with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= ASSERT;
      hold_cnt_q  <= '0;
      ch_idx_q    <= '0;
      dly_cnt_q   <= '0;
      dly_lat_q   <= '0;
      div_lat_q   <= '0;
      ch_resetn_q <= '0;
      rst_done_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      ch_idx_q    <= ch_idx_d;
      dly_cnt_q   <= dly_cnt_d;
      dly_lat_q   <= dly_lat_d;
      div_lat_q   <= div_lat_d;
      ch_resetn_q <= ch_resetn_d;
      rst_done_q  <= rst_done_d;
      busy_q      <= busy_d;
    end
  end

  // A divider runs only while its channel is released now and stays released
  // next cycle, so a software restart clears the enables on the same edge as
  // the resets, while a fresh release still starts counting one cycle later.
  assign run_s = ch_resetn_q & ch_resetn_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_div #(
      .DIV_W (DIV_W)
    ) u_clk_en_div (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .run       (run_s[g]),
      .div       (div_lat_q[g*DIV_W +: DIV_W]),
      .clk_en    (ch_clk_en[g])
    );
  end

  assign ch_resetn = ch_resetn_q;
  assign rst_done  = rst_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl. Cycle n is the period after edge n;
// inputs driven during cycle n are sampled at edge n+1.
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int VW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (defaults)
  logic              sys_reset;
  logic              sw_rst_req;
  logic [N*DW-1:0]   dly_cfg;
  logic [N*VW-1:0]   div_cfg;
  logic [N-1:0]      ch_resetn;
  logic [N-1:0]      ch_clk_en;
  logic              rst_done;
  logic              busy;

  // Single-channel DUT (NUM_CH=1, HOLD_CYC=1)
  logic              s_reset;
  logic              s_sw;
  logic [7:0]        s_dly;
  logic [7:0]        s_div;
  logic [0:0]        s_resetn;
  logic [0:0]        s_en;
  logic              s_done;
  logic              s_busy;

  rst_seq_ctrl #(.NUM_CH(N), .HOLD_CYC(H), .DLY_W(DW), .DIV_W(VW)) dut (
    .sys_clk    (clk),
    .sys_reset  (sys_reset),
    .dly_cfg    (dly_cfg),
    .div_cfg    (div_cfg),
    .sw_rst_req (sw_rst_req),
    .ch_resetn  (ch_resetn),
    .ch_clk_en  (ch_clk_en),
    .rst_done   (rst_done),
    .busy       (busy)
  );

  rst_seq_ctrl #(.NUM_CH(1), .HOLD_CYC(1), .DLY_W(8), .DIV_W(8)) dut_small (
    .sys_clk    (clk),
    .sys_reset  (s_reset),
    .dly_cfg    (s_dly),
    .div_cfg    (s_div),
    .sw_rst_req (s_sw),
    .ch_resetn  (s_resetn),
    .ch_clk_en  (s_en),
    .rst_done   (s_done),
    .busy       (s_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a sequence starts at cycle m_start (reset values there),
  // config is captured at cycle m_start+H, and release/enable times follow
  // from cumulative delays and divisor periods.
  int t = 0;
  int m_start = 0;
  int m_dly [N];
  int m_div [N];
  logic [N-1:0] e_resetn;
  logic [N-1:0] e_en;
  logic         e_done;
  logic         e_busy;

  function automatic void model_outputs(input int tc, output logic [N-1:0] rn,
                                        output logic [N-1:0] en, output logic dn);
    int r;
    rn = '0;
    en = '0;
    r  = m_start + H;
    for (int i = 0; i < N; i++) begin
      r = r + m_dly[i] + 1;
      if (tc >= r) begin
        rn[i] = 1'b1;
        if (tc > r && ((tc - r) % (m_div[i] + 1)) == 0) en[i] = 1'b1;
      end
    end
    dn = rn[N-1];
  endfunction

  task automatic tick();
    logic [N-1:0] prn;
    logic [N-1:0] pen;
    logic         pdn;
    model_outputs(t, prn, pen, pdn);
    @(posedge clk);
    #1;
    t = t + 1;
    if (sys_reset) m_start = t;
    else if (sw_rst_req && pdn) m_start = t;
    if (t == m_start + H) begin
      for (int i = 0; i < N; i++) begin
        m_dly[i] = int'(dly_cfg[i*DW +: DW]);
        m_div[i] = int'(div_cfg[i*VW +: VW]);
      end
    end
    model_outputs(t, e_resetn, e_en, e_done);
    e_busy = ~e_done;
  endtask

  task automatic load_defaults();
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd2};
    div_cfg = {8'd0, 8'd3, 8'd1, 8'd0};
  endtask

  task automatic test_reset();
    sys_reset  = 1'b1;
    sw_rst_req = 1'b0;
    load_defaults();
    tick();
    tick();
    t = 0;
    m_start = 0;
    sys_reset = 1'b0;
    checks++;
    if ({ch_resetn, ch_clk_en, rst_done, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got %b expected %b",
               {ch_resetn, ch_clk_en, rst_done, busy}, {4'b0000, 4'b0000, 1'b0, 1'b1});
    end
  endtask

  task automatic test_first_sequence();
    logic [N-1:0] xr;
    logic [N-1:0] xe;
    while (t < 30) begin
      tick();
      xr = (t >= 16) ? 4'b1111 : (t >= 14) ? 4'b0111 : (t >= 8) ? 4'b0011 :
           (t >= 7) ? 4'b0001 : 4'b0000;
      xe[0] = (t >= 8);
      xe[1] = (t >= 10) && (t % 2 == 0);
      xe[2] = (t >= 18) && ((t - 18) % 4 == 0);
      xe[3] = (t >= 17);
      checks++;
      if ({ch_resetn, rst_done, busy} !== {xr, (t >= 16), (t < 16)}) begin
        failures++;
        $display("FAIL release_times t=%0d: got %b expected %b", t,
                 {ch_resetn, rst_done, busy}, {xr, (t >= 16), (t < 16)});
      end
      checks++;
      if (ch_clk_en !== xe) begin
        failures++;
        $display("FAIL clk_en_pattern t=%0d: got %b expected %b", t, ch_clk_en, xe);
      end
      checks++;
      if ({ch_resetn, ch_clk_en, rst_done, busy} !== {e_resetn, e_en, e_done, e_busy}) begin
        failures++;
        $display("FAIL first_seq_model t=%0d: got %b expected %b", t,
                 {ch_resetn, ch_clk_en, rst_done, busy}, {e_resetn, e_en, e_done, e_busy});
      end
    end
  endtask

  task automatic test_sw_restart();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if ({ch_resetn, ch_clk_en, rst_done, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sw_restart_clear t=%0d: got %b expected %b", t,
               {ch_resetn, ch_clk_en, rst_done, busy}, {4'b0000, 4'b0000, 1'b0, 1'b1});
    end
    while (t < 40) begin
      tick();
      checks++;
      if (ch_resetn[0] !== (t >= 38)) begin
        failures++;
        $display("FAIL sw_restart_ch0 t=%0d: got %b expected %b", t, ch_resetn[0], (t >= 38));
      end
      checks++;
      if ({ch_resetn, ch_clk_en, rst_done, busy} !== {e_resetn, e_en, e_done, e_busy}) begin
        failures++;
        $display("FAIL sw_restart_model t=%0d: got %b expected %b", t,
                 {ch_resetn, ch_clk_en, rst_done, busy}, {e_resetn, e_en, e_done, e_busy});
      end
    end
  endtask

  task automatic test_ignored_in_release();
    logic [N-1:0] xr;
    while (t < 55) begin
      sw_rst_req = (t == 41);
      if (t == 42) begin
        dly_cfg = {$urandom, $urandom} & {N*DW{1'b1}};
        div_cfg = {$urandom, $urandom} & {N*VW{1'b1}};
      end
      tick();
      sw_rst_req = 1'b0;
      xr = (t >= 47) ? 4'b1111 : (t >= 45) ? 4'b0111 : 4'b0011;
      checks++;
      if ({ch_resetn, rst_done} !== {xr, (t >= 47)}) begin
        failures++;
        $display("FAIL latched_release t=%0d: got %b expected %b", t,
                 {ch_resetn, rst_done}, {xr, (t >= 47)});
      end
      checks++;
      if ({ch_resetn, ch_clk_en, rst_done, busy} !== {e_resetn, e_en, e_done, e_busy}) begin
        failures++;
        $display("FAIL ignore_model t=%0d: got %b expected %b", t,
                 {ch_resetn, ch_clk_en, rst_done, busy}, {e_resetn, e_en, e_done, e_busy});
      end
    end
  endtask

  task automatic test_sys_reset_abort();
    sys_reset = 1'b1;
    load_defaults();
    tick();
    t = 0;
    m_start = 0;
    sys_reset = 1'b0;
    while (t < 10) tick();
    checks++;
    if (ch_resetn !== 4'b0011) begin
      failures++;
      $display("FAIL abort_pre t=%0d: got %b expected %b", t, ch_resetn, 4'b0011);
    end
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    checks++;
    if ({ch_resetn, ch_clk_en, rst_done, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_reset t=%0d: got %b expected %b", t,
               {ch_resetn, ch_clk_en, rst_done, busy}, {4'b0000, 4'b0000, 1'b0, 1'b1});
    end
    while (t < 30) begin
      tick();
      checks++;
      if ({ch_resetn[0], rst_done} !== {(t >= 18), (t >= 27)}) begin
        failures++;
        $display("FAIL abort_restart t=%0d: got %b expected %b", t,
                 {ch_resetn[0], rst_done}, {(t >= 18), (t >= 27)});
      end
      checks++;
      if ({ch_resetn, ch_clk_en, rst_done, busy} !== {e_resetn, e_en, e_done, e_busy}) begin
        failures++;
        $display("FAIL abort_model t=%0d: got %b expected %b", t,
                 {ch_resetn, ch_clk_en, rst_done, busy}, {e_resetn, e_en, e_done, e_busy});
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      sys_reset  = ($urandom_range(0, 299) == 0);
      sw_rst_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) begin
        for (int i = 0; i < N; i++) begin
          dly_cfg[i*DW +: DW] = DW'($urandom_range(0, 6));
          div_cfg[i*VW +: VW] = VW'($urandom_range(0, 4));
        end
      end
      tick();
      checks++;
      if ({ch_resetn, ch_clk_en, rst_done, busy} !== {e_resetn, e_en, e_done, e_busy}) begin
        failures++;
        $display("FAIL random_model t=%0d: got %b expected %b", t,
                 {ch_resetn, ch_clk_en, rst_done, busy}, {e_resetn, e_en, e_done, e_busy});
      end
    end
    sys_reset  = 1'b0;
    sw_rst_req = 1'b0;
  endtask

  task automatic test_single_channel();
    int base;
    int s;
    int c;
    logic xr;
    logic xe;
    s_reset = 1'b1;
    s_dly   = 8'd0;
    s_div   = 8'd1;
    tick();
    base = t;
    s_reset = 1'b0;
    s = 0;
    for (int k = 1; k <= 16; k++) begin
      c = t - base;
      s_sw = (c == 8);
      tick();
      s_sw = 1'b0;
      c = t - base;
      if (c == 9) s = 9;
      xr = (c >= s + 2);
      xe = (c > s + 2) && ((c - (s + 2)) % 2 == 0);
      checks++;
      if ({s_resetn, s_en, s_done, s_busy} !== {xr, xe, xr, ~xr}) begin
        failures++;
        $display("FAIL single_channel c=%0d: got %b expected %b", c,
                 {s_resetn, s_en, s_done, s_busy}, {xr, xe, xr, ~xr});
      end
    end
  endtask

  initial begin
    sys_reset  = 1'b1;
    sw_rst_req = 1'b0;
    s_reset    = 1'b1;
    s_sw       = 1'b0;
    s_dly      = 8'd0;
    s_div      = 8'd1;
    for (int i = 0; i < N; i++) begin
      m_dly[i] = 0;
      m_div[i] = 0;
    end
    load_defaults();
    test_reset();
    test_first_sequence();
    test_sw_restart();
    test_ignored_in_release();
    test_sys_reset_abort();
    test_random();
    test_single_channel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset sequencer and clock-enable generator for the IP subsystem.
- Holds NUM_CH downstream reset domains in reset for a minimum time after sys_reset is deasserted.
- Releases the domains in order, channel 0 first, with a programmable per-channel delay between releases.
- After each channel is released, generates its divided clock-enable. Software can re-trigger the full sequence.

Parameters:
- NUM_CH, 4, number of reset/enable channels (1..16).
- HOLD_CYC, 4, cycles all channels stay in reset after sys_reset deasserts or after a sw_rst_req (>=1).
- DLY_W, 8, width of each per-channel release delay.
- DIV_W, 8, width of each per-channel clock-enable divisor.

Ports:
- sys_clk  in  1  single system clock, rising edge.
- sys_reset  in  1  synchronous active-high reset.
- dly_cfg  in  NUM_CH*DLY_W  packed release delays; channel i at [i*DLY_W +: DLY_W].
- div_cfg  in  NUM_CH*DIV_W  packed divisors; channel i at [i*DIV_W +: DIV_W].
- sw_rst_req  in  1  pulse that re-runs the sequence; honoured only in DONE.
- ch_resetn  out  NUM_CH  per-domain active-low reset.
- ch_clk_en  out  NUM_CH  per-domain clock enable.
- rst_done  out  1  high when every channel is released.
- busy  out  1  high in ASSERT or RELEASE.

Behaviour:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high. sys_clk / sys_reset are the only clock/reset. All outputs are registered.
- While sys_reset=1, the next edge gives: state=ASSERT, ch_resetn=0, ch_clk_en=0, rst_done=0, busy=1, all counters 0.
- sys_reset is honoured in any state, including mid-RELEASE, and aborts the sequence (same values as above).
- FSM states: ASSERT, RELEASE, DONE.
- ASSERT:
  - hold_cnt increments each cycle.
  - At hold_cnt==HOLD_CYC-1: go to RELEASE, clear ch_idx and dly_cnt, and latch dly_cfg/div_cfg into internal registers.
  - Config changes after the latch have no effect until the next ASSERT.
- Cycle numbering: cycle 0 is the first edge with sys_reset=0. RELEASE is entered at cycle HOLD_CYC.
- RELEASE:
  - dly_cnt counts from 0. When dly_cnt==dly[ch_idx], ch_resetn[ch_idx] goes high at that edge, dly_cnt clears and ch_idx increments.
  - Channel 0 goes high dly[0]+1 cycles after RELEASE entry.
  - Channel i goes high dly[i]+1 cycles after channel i-1.
  - dly=0 gives back-to-back releases on consecutive cycles.
  - Releasing channel NUM_CH-1 moves the FSM to DONE. rst_done=1 and busy=0 on that same edge.
- DONE:
  - Outputs are stable.
  - sw_rst_req=1 gives, at the next edge: state=ASSERT, all ch_resetn=0, ch_clk_en=0, rst_done=0, busy=1, hold_cnt=0. The HOLD_CYC hold then repeats.
  - sw_rst_req is ignored in ASSERT and RELEASE (no queuing).
- Clock enable, per channel:
  - div_cnt[i] is held at 0 and ch_clk_en[i]=0 while ch_resetn[i]=0.
  - Once ch_resetn[i]=1, div_cnt counts 0..div[i] and wraps to 0.
  - ch_clk_en[i] is a registered one-cycle pulse. It is high on the cycle div_cnt wraps, i.e. first pulse div[i]+1 cycles after ch_resetn[i] rises, then every div[i]+1 cycles.
  - div=0: ch_clk_en[i] is constantly high from the cycle after release.
- Arithmetic: all counters are unsigned and wrap only at the compare value; there is no overflow path. hold_cnt is clog2(HOLD_CYC)+1 bits.
- Channel invariant: ch_resetn is monotonic during one sequence. A lower-index channel is never released after a higher one.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum (ASSERT=2'd0, RELEASE=2'd1, DONE=2'd2);
  - helper localparam for the ch_idx width, clog2(NUM_CH).
- Sub-module clk_en_div is instantiated NUM_CH times via generate.
  - Ports: sys_clk, sys_reset, run (=ch_resetn[i]), div (DIV_W), clk_en.
  - Holds the div_cnt and the pulse register.

Test Plan:
- Defaults, dly={ch0:2, ch1:0, ch2:5, ch3:1}, sys_reset high then low -> ch_resetn bits rise at cycles 7, 8, 14, 16; rst_done and busy=0 at cycle 16.
- div_cfg={ch0:0, ch1:1, ch2:3, ch3:0}, same run -> ch0 clk_en high from cycle 8 continuously; ch1 pulses at 10, 12, 14…; ch2 pulses at 18, 22, …; ch3 high from 17.
- sw_rst_req pulse in DONE at cycle 30 -> all ch_resetn and ch_clk_en low at 31, busy=1; ch0 re-releases at 31+4+3=38.
- sw_rst_req during RELEASE, and dly_cfg changed mid-RELEASE -> both ignored; release times match the latched config.
- sys_reset asserted at cycle 10 (ch0, ch1 released) -> all outputs return to reset values next edge; full sequence restarts from cycle 0 after deassert.
- NUM_CH=1, HOLD_CYC=1, dly=0 -> ch_resetn[0] and rst_done high at cycle 2.
